// File: rtl/oled_disp_sched.sv
// oled_disp_sched: shares one IIC byte-triple writer between the init sequencer, screen
// clear, static label writer and live-data writer. After power-up it runs
// init -> clear -> static once, then runs data refresh passes on a periodic tick or a
// new-sample pulse.
// Optional feature macro: OLED_AUTO_REINIT_EN (forced re-init every REINIT_CNT data passes).
module oled_disp_sched #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned PWRUP_MS   = 20,
  parameter int unsigned REFRESH_MS = 500,
  parameter int unsigned REINIT_CNT = 64
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        data_update,
  output logic        init_req,
  input  logic [23:0] init_data,
  input  logic        init_finish,
  output logic        clear_req,
  input  logic [23:0] clear_data,
  input  logic        clear_finish,
  output logic        static_req,
  input  logic [23:0] static_data,
  input  logic        static_finish,
  output logic        data_req,
  input  logic [23:0] data_data,
  input  logic        data_finish,
  output logic        iic_wr_req,
  output logic [23:0] iic_wr_data,
  input  logic        iic_write_done,
  output logic        client_wr_done,
  output logic        busy
);

  // Cycle counts are computed in 64 bits: REFRESH_MS*CLK_FREQ overflows 32 bits at 50 MHz.
  localparam longint unsigned PWRUP_CYC   = 64'(PWRUP_MS) * 64'(CLK_FREQ) / 64'd1000;
  localparam longint unsigned REFRESH_CYC = 64'(REFRESH_MS) * 64'(CLK_FREQ) / 64'd1000;
  localparam int PW = (PWRUP_CYC > 64'd1) ? $clog2(PWRUP_CYC) : 1;
  localparam int RW = (REFRESH_CYC > 64'd1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [PW-1:0] PWRUP_LAST   = PW'(PWRUP_CYC - 64'd1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYC - 64'd1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_CLEAR, S_STATIC, S_WAIT, S_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pwrup_cnt;
  logic [RW-1:0]   refresh_cnt;
  logic            tick;
  logic            pend;
  logic            pend_clr;

`ifdef OLED_AUTO_REINIT_EN
  localparam logic [7:0] REINIT_TGT = 8'(REINIT_CNT);
  logic [7:0] pass_cnt;
  logic       reinit_hit;

  // The pass that brings the count up to REINIT_CNT is the one that diverts to init.
  assign reinit_hit = ((pass_cnt + 8'd1) == REINIT_TGT);

  // Pass counter: counts finished data passes, restarts when a re-init is taken.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      pass_cnt <= '0;
    else if (state_q == S_DATA && data_finish)
      pass_cnt <= reinit_hit ? 8'd0 : pass_cnt + 8'd1;
  end
`else
  // REINIT_CNT has no effect without auto re-init; both builds keep one parameter list.
  if (REINIT_CNT == 0) begin : g_reinit_unused
  end
`endif

  assign tick = (refresh_cnt == REFRESH_LAST);

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_PWRUP;
    else        state_q <= state_d;
  end

  // Power-up delay: counts only while in S_PWRUP, so re-entry always waits the full time.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                 pwrup_cnt <= '0;
    else if (state_q == S_PWRUP) pwrup_cnt <= pwrup_cnt + PW'(1);
    else                        pwrup_cnt <= '0;
  end

  // Free-running refresh timer, wrapping once per refresh period.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)    refresh_cnt <= '0;
    else if (tick) refresh_cnt <= '0;
    else           refresh_cnt <= refresh_cnt + RW'(1);
  end

  // Pending-refresh flag: a new request in the same cycle as the clear must not be lost.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= tick | data_update | (pend & ~pend_clr);
  end

  // Next-state logic; each *_finish only counts in its own state.
  always_comb begin
    state_d  = state_q;
    pend_clr = 1'b0;
    case (state_q)
      S_PWRUP:  if (pwrup_cnt == PWRUP_LAST) state_d = S_INIT;
      S_INIT:   if (init_finish)             state_d = S_CLEAR;
      S_CLEAR:  if (clear_finish)            state_d = S_STATIC;
      S_STATIC: if (static_finish)           state_d = S_WAIT;
      S_WAIT: begin
        if (pend) begin
          state_d  = S_DATA;
          pend_clr = 1'b1;
        end
      end
      S_DATA: begin
        if (data_finish) begin
`ifdef OLED_AUTO_REINIT_EN
          state_d = reinit_hit ? S_INIT : S_WAIT;
`else
          state_d = S_WAIT;
`endif
        end
      end
      default:  state_d = S_PWRUP;
    endcase
  end

  // Grants are registered from the next state so they rise on state entry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      init_req   <= 1'b0;
      clear_req  <= 1'b0;
      static_req <= 1'b0;
      data_req   <= 1'b0;
    end else begin
      init_req   <= (state_d == S_INIT);
      clear_req  <= (state_d == S_CLEAR);
      static_req <= (state_d == S_STATIC);
      data_req   <= (state_d == S_DATA);
    end
  end

  // Write channel mux; finish masks the request so no new IIC start slips in before req falls.
  always_comb begin
    iic_wr_data = '0;
    iic_wr_req  = 1'b0;
    case (state_q)
      S_INIT: begin
        iic_wr_data = init_data;
        iic_wr_req  = init_req & ~init_finish;
      end
      S_CLEAR: begin
        iic_wr_data = clear_data;
        iic_wr_req  = clear_req & ~clear_finish;
      end
      S_STATIC: begin
        iic_wr_data = static_data;
        iic_wr_req  = static_req & ~static_finish;
      end
      S_DATA: begin
        iic_wr_data = data_data;
        iic_wr_req  = data_req & ~data_finish;
      end
      default: begin
        iic_wr_data = '0;
        iic_wr_req  = 1'b0;
      end
    endcase
  end

  assign client_wr_done = iic_write_done & (init_req | clear_req | static_req | data_req);
  assign busy           = (state_q != S_WAIT);

endmodule
